// File: rtl/if_prefetch_if.sv
// Bus bundle for the instruction prefetcher: memory request/response,
// branch redirect and decode-side handshake.
// Optional macro IF_PREFETCH_ABS_EN adds the REDIR_ABS signal.
interface if_prefetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 16
);
  logic              IMEM_REQ;
  logic [ADDR_W-1:0] IMEM_ADDR;
  logic              IMEM_GNT;
  logic              IMEM_RVALID;
  logic [INST_W-1:0] IMEM_RDATA;
  logic              REDIR;
  logic [ADDR_W-1:0] REDIR_PC;
  logic [ADDR_W-1:0] REDIR_OFFSET;
`ifdef IF_PREFETCH_ABS_EN
  logic              REDIR_ABS;
`endif
  logic              FVALID;
  logic [INST_W-1:0] FINST;
  logic [ADDR_W-1:0] FPC;
  logic              FREADY;

  // Prefetcher side
  modport master (
    output IMEM_REQ, IMEM_ADDR, FVALID, FINST, FPC,
`ifdef IF_PREFETCH_ABS_EN
    input  REDIR_ABS,
`endif
    input  IMEM_GNT, IMEM_RVALID, IMEM_RDATA, REDIR, REDIR_PC, REDIR_OFFSET, FREADY
  );

  // Memory / branch unit / decode side
  modport slave (
    input  IMEM_REQ, IMEM_ADDR, FVALID, FINST, FPC,
`ifdef IF_PREFETCH_ABS_EN
    output REDIR_ABS,
`endif
    output IMEM_GNT, IMEM_RVALID, IMEM_RDATA, REDIR, REDIR_PC, REDIR_OFFSET, FREADY
  );
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: single-outstanding fetch FSM feeding a
// DEPTH-entry FIFO of {instruction, PC} pairs, with branch redirect flush.
// Optional macro IF_PREFETCH_ABS_EN: REDIR_ABS selects an absolute target.
module if_prefetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           CLK,
  input logic           nRESET,
  if_prefetch_if.master bus
);

  localparam int unsigned       PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INST_W / 8);
  localparam logic [PTR_W:0]    FULL  = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] gnt_pc;
  logic [ADDR_W-1:0] target;

  logic [INST_W-1:0] q_inst [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    count_next;
  logic              fvalid;
  logic              push;
  logic              pop;

  // Redirect target address
  always_comb begin
`ifdef IF_PREFETCH_ABS_EN
    target = bus.REDIR_ABS ? bus.REDIR_OFFSET : bus.REDIR_PC + bus.REDIR_OFFSET;
`else
    target = bus.REDIR_PC + bus.REDIR_OFFSET;
`endif
  end

  // Queue handshake and next occupancy; a redirect cancels both push and pop
  always_comb begin
    fvalid = (count != '0);
    push   = (state == S_WAIT) && bus.IMEM_RVALID && !bus.REDIR;
    pop    = fvalid && bus.FREADY && !bus.REDIR;
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  // Fetch FSM: request sequencing, fetch PC and granted address
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      gnt_pc <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.REDIR) begin
            pc    <= target;
            state <= S_REQ;
          end else if (count != FULL) begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.REDIR) begin
            pc <= target;
          end else if (bus.IMEM_GNT) begin
            gnt_pc <= pc;
            pc     <= pc + STEP;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.REDIR) begin
            pc    <= target;
            state <= bus.IMEM_RVALID ? S_REQ : S_DISCARD;
          end else if (bus.IMEM_RVALID) begin
            state <= (count_next != FULL) ? S_REQ : S_IDLE;
          end
        end
        S_DISCARD: begin
          if (bus.REDIR)
            pc <= target;
          // A word arriving alongside a further redirect is the one being
          // discarded, so nothing is left in flight: go straight to REQ.
          if (bus.IMEM_RVALID)
            state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Queue pointers and occupancy, cleared on redirect
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.REDIR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Queue storage; contents are only visible while occupancy is non-zero
  always_ff @(posedge CLK) begin
    if (push) begin
      q_inst[wr_ptr] <= bus.IMEM_RDATA;
      q_pc[wr_ptr]   <= gnt_pc;
    end
  end

  // Output drive
  always_comb begin
    bus.IMEM_REQ  = (state == S_REQ);
    bus.IMEM_ADDR = pc;
    bus.FVALID    = fvalid;
    bus.FINST     = fvalid ? q_inst[rd_ptr] : '0;
    bus.FPC       = fvalid ? q_pc[rd_ptr]   : '0;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter ADDR_W, default 32, fetch address and PC width.
REQ-002 Parameter INST_W, default 16, instruction width; PC step is INST_W/8 bytes (2 at default).
REQ-003 Parameter DEPTH, default 4, prefetch queue entries, power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0, fetch address after reset.
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 nRESET  in  1  asynchronous, active-low reset.
REQ-007 IMEM_REQ  out  1  fetch request; IMEM_ADDR  out  ADDR_W  fetch address.
REQ-008 IMEM_GNT  in  1  memory accepts the request this cycle.
REQ-009 IMEM_RVALID  in  1  read data valid; IMEM_RDATA  in  INST_W  instruction word.
REQ-010 REDIR  in  1  branch redirect; REDIR_PC  in  ADDR_W  branch base PC; REDIR_OFFSET  in  ADDR_W  signed offset.
REQ-011 FVALID  out  1  head entry valid; FINST  out  INST_W  head instruction; FPC  out  ADDR_W  head PC.
REQ-012 FREADY  in  1  decode accepts the head entry when FVALID and FREADY are both 1.

Function
REQ-013 The block SHALL hold at most one outstanding memory request, from grant until the matching IMEM_RVALID.
REQ-014 States: IDLE, REQ (IMEM_REQ=1, awaiting grant), WAIT (granted, awaiting data), DISCARD (awaiting a data word to drop).
REQ-015 IDLE->REQ when occupancy < DEPTH; REQ->WAIT on IMEM_GNT; WAIT->IDLE on IMEM_RVALID, or WAIT->REQ on IMEM_RVALID if occupancy after the push is still < DEPTH.
REQ-016 In REQ, IMEM_ADDR SHALL stay stable until IMEM_GNT unless REDIR is asserted.
REQ-017 On grant, the fetch PC SHALL advance by INST_W/8, modulo 2^ADDR_W.
REQ-018 On IMEM_RVALID in WAIT, {IMEM_RDATA, granted address} SHALL be pushed to the queue tail.
REQ-019 Pop on FVALID & FREADY. Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-020 FINST and FPC SHALL be 0 whenever FVALID=0.
REQ-021 Full queue: no new request; an in-flight word SHALL always have a free slot, guaranteed by the REQ-015 entry condition.
REQ-022 REDIR target SHALL be REDIR_PC + REDIR_OFFSET, modulo 2^ADDR_W.
REQ-023 REDIR SHALL flush the queue; FVALID=0 in the next cycle. Any pop in the same cycle is ignored.
REQ-024 REDIR SHALL load the target into the fetch PC.
REQ-025 REDIR in IDLE or REQ: next state REQ with IMEM_ADDR = target. A pending ungranted request is withdrawn, even if IMEM_GNT is high that cycle.
REQ-026 REDIR in WAIT or DISCARD: next state DISCARD. The next IMEM_RVALID word SHALL be dropped, then state goes to REQ at the target.
REQ-027 REDIR concurrent with IMEM_RVALID in WAIT: the word SHALL be dropped and the next state SHALL be REQ at the target.
REQ-028 First valid instruction latency from a request: 1 cycle after IMEM_RVALID.

Reset
REQ-029 While nRESET=0: state IDLE, fetch PC RESET_PC, occupancy 0, IMEM_REQ 0, IMEM_ADDR RESET_PC, FVALID 0, FINST 0, FPC 0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request. A stray IMEM_RVALID in IDLE SHALL be ignored.

Configuration
REQ-031 Macro IF_PREFETCH_ABS_EN defined: input REDIR_ABS (1 bit) exists; REDIR with REDIR_ABS=1 targets REDIR_OFFSET directly, ignoring REDIR_PC.
REQ-032 Macro IF_PREFETCH_ABS_EN undefined: no REDIR_ABS port; all redirects are PC-relative per REQ-022.

Verification
REQ-033 Reset with defaults, memory grants immediately with 1-cycle data latency, FREADY=1: IMEM_ADDR sequence 0,2,4,...; FPC tracks the same sequence; FINST equals the returned data.
REQ-034 FREADY=0 for 10 cycles: exactly 4 entries fill, then IMEM_REQ=0; after FREADY=1, entries drain in order 0,2,4,6.
REQ-035 REDIR in WAIT with REDIR_PC=0x100, REDIR_OFFSET=0xFFFFFFFC: the late data word is dropped; next IMEM_ADDR=0xFC; first FPC after the redirect is 0xFC.
REQ-036 REDIR in REQ while IMEM_GNT=1: the grant is ignored, and the next request carries the target address.
REQ-037 Fetch PC at 0xFFFFFFFE: next IMEM_ADDR wraps to 0x0.
REQ-038 With IF_PREFETCH_ABS_EN, REDIR_ABS=1, REDIR_OFFSET=0x2000: next IMEM_ADDR=0x2000 regardless of REDIR_PC.
